// File: rtl/mem_cache_dm_param.sv
// mem_cache_dm_param
//   Direct-mapped, write-back, write-allocate cache between a word-wide CPU
//   port and a line-wide host DMA port. Tag/data/valid/dirty are flop arrays.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   rd, wr, addr, data_in    CPU request (wr wins over rd); held until done
//   data_out, data_valid     read data, qualified by data_valid
//   done, CacheHit           one-cycle completion pulse, hit qualifier
//   DataIn_host, rd_valid_host   line fill from host and its completion strobe
//   tx_done_host             host accepted the eviction line
//   DataOut_host, AddrOut_host, op_host   host command (00 none/01 read/10 write)
//
// Optional feature: define MEM_CACHE_STATS_EN to add saturating
// hit_count / miss_count outputs, counted once per done.
//
// Assumes LINE_W holds at least two words (word select is at least 1 bit).

module mem_cache_dm_param #(
    parameter int ADDR_W    = 32,
    parameter int WORD_W    = 32,
    parameter int LINE_W    = 512,
    parameter int NUM_LINES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              done,
    output logic              CacheHit,
    input  logic [LINE_W-1:0] DataIn_host,
    input  logic              rd_valid_host,
    input  logic              tx_done_host,
    output logic [LINE_W-1:0] DataOut_host,
    output logic [ADDR_W-1:0] AddrOut_host,
`ifdef MEM_CACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    output logic [1:0]        op_host
);

    localparam int OFS    = $clog2(LINE_W / 8);
    localparam int IDX    = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - OFS - IDX;
    localparam int WLSB   = $clog2(WORD_W / 8);
    localparam int WSEL_W = $clog2(LINE_W / WORD_W);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_EVICT  = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    logic [2:0]           state;
    logic [TAG_W-1:0]     req_tag;
    logic [IDX-1:0]       req_idx;
    logic [WSEL_W-1:0]    req_wsel;
    logic [WORD_W-1:0]    req_wdata;
    logic                 req_wr;
    logic                 hit_q;

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem [NUM_LINES];

    logic [LINE_W-1:0]    line_cur;
    logic [WORD_W-1:0]    cur_word;
    logic [WORD_W-1:0]    fill_word;
    logic                 lookup_hit;
    logic                 unused_bits;

    // Byte-within-word bits never reach the array.
    assign unused_bits = ^addr[WLSB-1:0];

    assign line_cur   = data_mem[req_idx];
    assign cur_word   = line_cur[req_wsel*WORD_W +: WORD_W];
    assign fill_word  = DataIn_host[req_wsel*WORD_W +: WORD_W];
    assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    // Response flags are decoded from state so they cannot outlive RESPOND.
    assign done       = (state == S_RESP);
    assign data_valid = done && !req_wr;
    assign CacheHit   = done && hit_q;

    always_comb begin
        op_host = OP_NONE;
        if (state == S_EVICT)     op_host = OP_WRITE;
        else if (state == S_FILL) op_host = OP_READ;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            valid        <= '0;
            dirty        <= '0;
            req_tag      <= '0;
            req_idx      <= '0;
            req_wsel     <= '0;
            req_wdata    <= '0;
            req_wr       <= 1'b0;
            hit_q        <= 1'b0;
            data_out     <= '0;
            AddrOut_host <= '0;
            DataOut_host <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rd || wr) begin
                        req_tag   <= addr[OFS+IDX +: TAG_W];
                        req_idx   <= addr[OFS +: IDX];
                        req_wsel  <= addr[WLSB +: WSEL_W];
                        req_wdata <= data_in;
                        req_wr    <= wr;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lookup_hit) begin
                        hit_q <= 1'b1;
                        if (!req_wr) data_out <= cur_word;
                        state <= S_RESP;
                    end else if (valid[req_idx] && dirty[req_idx]) begin
                        // Victim image is captured once and held through the handshake.
                        AddrOut_host <= {tag_mem[req_idx], req_idx, {OFS{1'b0}}};
                        DataOut_host <= line_cur;
                        state        <= S_EVICT;
                    end else begin
                        AddrOut_host <= {req_tag, req_idx, {OFS{1'b0}}};
                        state        <= S_FILL;
                    end
                end
                S_EVICT: begin
                    if (tx_done_host) begin
                        dirty[req_idx] <= 1'b0;
                        AddrOut_host   <= {req_tag, req_idx, {OFS{1'b0}}};
                        state          <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (rd_valid_host) begin
                        valid[req_idx] <= 1'b1;
                        dirty[req_idx] <= 1'b0;
                        hit_q          <= 1'b0;
                        if (!req_wr) data_out <= fill_word;
                        state          <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (req_wr) dirty[req_idx] <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Array contents need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (state == S_FILL && rd_valid_host) begin
            data_mem[req_idx] <= DataIn_host;
            tag_mem[req_idx]  <= req_tag;
        end else if (state == S_RESP && req_wr) begin
            data_mem[req_idx][req_wsel*WORD_W +: WORD_W] <= req_wdata;
        end
    end

`ifdef MEM_CACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == S_RESP) begin
            if (hit_q) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_cache_dm_param.sv
// Bench for mem_cache_dm_param at default parameters: directed vector table,
// hand-written reset/idle-strobe sequences, then a random run against a flat
// word-memory reference.

module tb_mem_cache_dm_param;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd, wr;
    logic [31:0]  addr, data_in, data_out;
    logic         data_valid, done, CacheHit;
    logic [511:0] DataIn_host, DataOut_host;
    logic         rd_valid_host, tx_done_host;
    logic [31:0]  AddrOut_host;
    logic [1:0]   op_host;
`ifdef MEM_CACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
`endif

    mem_cache_dm_param dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(data_out), .data_valid(data_valid), .done(done), .CacheHit(CacheHit),
        .DataIn_host(DataIn_host), .rd_valid_host(rd_valid_host), .tx_done_host(tx_done_host),
        .DataOut_host(DataOut_host), .AddrOut_host(AddrOut_host),
`ifdef MEM_CACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .op_host(op_host)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Host backing store and independent reference, both word-addressed.
    logic [31:0] hmem [logic [31:0]];
    logic [31:0] refm [logic [31:0]];

    function automatic logic [31:0] host_word(input logic [31:0] a);
        if (hmem.exists(a)) return hmem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (refm.exists(a)) return refm[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic init_mem();
        hmem.delete();
        refm.delete();
        hmem[32'h6004] = 32'hDEAD_BEEF;
        refm[32'h6004] = 32'hDEAD_BEEF;
    endtask

    // Issue one request from an IDLE-cycle negedge, act as host, and return
    // one cycle after done so the next request lands in IDLE.
    task automatic do_req(
        input  logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input int dly,
        output logic ok, output logic o_hit, output logic o_dv, output logic [31:0] o_data,
        output int o_lat, output logic ev_seen, output logic [31:0] ev_addr,
        output logic [511:0] ev_line, output logic ev_stable,
        output logic fl_seen, output logic [31:0] fl_addr, output int fl_lat);
        int cyc, wcnt, rv_cyc;
        logic [31:0] base;
        ok = 0; o_hit = 0; o_dv = 0; o_data = 0; o_lat = 0;
        ev_seen = 0; ev_addr = 0; ev_line = '0; ev_stable = 1;
        fl_seen = 0; fl_addr = 0; fl_lat = -1;
        cyc = 0; wcnt = 0; rv_cyc = -100;
        rd = r; wr = w; addr = a; data_in = d;
        while (cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            rd_valid_host = 1'b0;
            tx_done_host  = 1'b0;
            if (done) begin
                ok = 1; o_hit = CacheHit; o_dv = data_valid; o_data = data_out;
                o_lat = cyc; fl_lat = cyc - rv_cyc;
                break;
            end
            if (op_host == 2'b10) begin
                if (!ev_seen) begin
                    ev_seen = 1; ev_addr = AddrOut_host; ev_line = DataOut_host;
                end else if (ev_addr !== AddrOut_host || ev_line !== DataOut_host) begin
                    ev_stable = 0;
                end
                if (wcnt >= dly) begin
                    for (int k = 0; k < 16; k++) hmem[AddrOut_host + 32'(k*4)] = DataOut_host[k*32 +: 32];
                    tx_done_host = 1'b1;
                    wcnt = 0;
                end else wcnt++;
            end else if (op_host == 2'b01) begin
                if (!fl_seen) begin
                    fl_seen = 1; fl_addr = AddrOut_host;
                end
                if (wcnt >= dly) begin
                    base = AddrOut_host;
                    for (int k = 0; k < 16; k++) DataIn_host[k*32 +: 32] = host_word(base + 32'(k*4));
                    rd_valid_host = 1'b1;
                    rv_cyc = cyc;
                    wcnt = 0;
                end else wcnt++;
            end
        end
        rd = 1'b0; wr = 1'b0;
        if (ok && w) refm[a] = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        r, w;
        logic [31:0] a, d;
        int          dly;
        logic        hit;
        logic [31:0] data;
        logic        ev;
        logic [31:0] ev_addr;
        int          ev_w;
        logic [31:0] ev_word;
        logic        fl;
        logic [31:0] fl_addr;
    } vec_t;

    vec_t tbl [12];

    logic         ok, o_hit, o_dv, ev_seen, ev_stable, fl_seen;
    logic [31:0]  o_data, ev_addr, fl_addr;
    logic [511:0] ev_line;
    int           o_lat, fl_lat;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'h6004, 32'h0,         1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0,    0, 32'h0,         1'b1, 32'h6000};
        tbl[1]  = '{1'b1, 1'b0, 32'h6004, 32'h0,         0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,    0, 32'h0,         1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 32'h6008, 32'h1234,      0, 1'b1, 32'h0,         1'b0, 32'h0,    0, 32'h0,         1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'h6008, 32'h0,         0, 1'b1, 32'h1234,      1'b0, 32'h0,    0, 32'h0,         1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'h7008, 32'h0,         2, 1'b0, 32'h5A5A_7008, 1'b1, 32'h6000, 2, 32'h1234,      1'b1, 32'h7000};
        tbl[5]  = '{1'b1, 1'b0, 32'h6008, 32'h0,         1, 1'b0, 32'h1234,      1'b0, 32'h0,    0, 32'h0,         1'b1, 32'h6000};
        tbl[6]  = '{1'b0, 1'b1, 32'h8010, 32'hCAFE_F00D, 0, 1'b0, 32'h0,         1'b0, 32'h0,    0, 32'h0,         1'b1, 32'h8000};
        tbl[7]  = '{1'b1, 1'b0, 32'h8010, 32'h0,         0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0,    0, 32'h0,         1'b0, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0014, 32'h0,         0, 1'b0, 32'h5A5A_0014, 1'b1, 32'h8000, 4, 32'hCAFE_F00D, 1'b1, 32'h0000};
        tbl[9]  = '{1'b1, 1'b0, 32'hFFFC, 32'h0,         3, 1'b0, 32'h5A5A_FFFC, 1'b0, 32'h0,    0, 32'h0,         1'b1, 32'hFFC0};
        tbl[10] = '{1'b1, 1'b1, 32'hFFF8, 32'h1111_2222, 0, 1'b1, 32'h0,         1'b0, 32'h0,    0, 32'h0,         1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'hFFF8, 32'h0,         0, 1'b1, 32'h1111_2222, 1'b0, 32'h0,    0, 32'h0,         1'b0, 32'h0};

        rst = 1'b1; rd = 0; wr = 0; addr = 0; data_in = 0;
        DataIn_host = '0; rd_valid_host = 0; tx_done_host = 0;
        init_mem();
        repeat (3) @(negedge clk);
        chk("rst done", {31'b0, done}, 32'h0);
        chk("rst data_valid", {31'b0, data_valid}, 32'h0);
        chk("rst CacheHit", {31'b0, CacheHit}, 32'h0);
        chk("rst data_out", data_out, 32'h0);
        chk("rst op_host", {30'b0, op_host}, 32'h0);
        chk("rst AddrOut_host", AddrOut_host, 32'h0);
        chk("rst DataOut_host_or", {31'b0, |DataOut_host}, 32'h0);
`ifdef MEM_CACHE_STATS_EN
        chk("rst hit_count", hit_count, 32'h0);
        chk("rst miss_count", miss_count, 32'h0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            do_req(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].dly, ok, o_hit, o_dv, o_data,
                   o_lat, ev_seen, ev_addr, ev_line, ev_stable, fl_seen, fl_addr, fl_lat);
            chk($sformatf("v%0d done", i), {31'b0, ok}, 32'h1);
            chk($sformatf("v%0d CacheHit", i), {31'b0, o_hit}, {31'b0, tbl[i].hit});
            chk($sformatf("v%0d data_valid", i), {31'b0, o_dv}, {31'b0, tbl[i].r & ~tbl[i].w});
            if (tbl[i].r && !tbl[i].w) chk($sformatf("v%0d data_out", i), o_data, tbl[i].data);
            if (tbl[i].hit) chk($sformatf("v%0d hit_latency", i), o_lat, 32'd2);
            chk($sformatf("v%0d evict_seen", i), {31'b0, ev_seen}, {31'b0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("v%0d evict_addr", i), ev_addr, tbl[i].ev_addr);
                chk($sformatf("v%0d evict_word", i), ev_line[tbl[i].ev_w*32 +: 32], tbl[i].ev_word);
                chk($sformatf("v%0d evict_stable", i), {31'b0, ev_stable}, 32'h1);
            end
            chk($sformatf("v%0d fill_seen", i), {31'b0, fl_seen}, {31'b0, tbl[i].fl});
            if (tbl[i].fl) begin
                chk($sformatf("v%0d fill_addr", i), fl_addr, tbl[i].fl_addr);
                chk($sformatf("v%0d fill_to_done", i), fl_lat, 32'd1);
            end
        end

        // Host strobes in IDLE must be ignored
        begin
            logic bad;
            bad = 0;
            rd_valid_host = 1'b1; tx_done_host = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (done || op_host != 2'b00) bad = 1;
            end
            rd_valid_host = 1'b0; tx_done_host = 1'b0;
            chk("idle_strobes_quiet", {31'b0, bad}, 32'h0);
            do_req(1'b1, 1'b0, 32'hFFF8, 32'h0, 0, ok, o_hit, o_dv, o_data,
                   o_lat, ev_seen, ev_addr, ev_line, ev_stable, fl_seen, fl_addr, fl_lat);
            chk("idle_strobes_hit", {31'b0, o_hit}, 32'h1);
            chk("idle_strobes_data", o_data, 32'h1111_2222);
        end

        // Reset while FILL is pending
        begin
            int n;
            n = 0;
            rd = 1'b1; addr = 32'h6004;
            while (op_host != 2'b01 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("rstfill reached_fill", {30'b0, op_host}, 32'h1);
            rst = 1'b1;
            @(negedge clk);
            chk("rstfill op_host", {30'b0, op_host}, 32'h0);
            chk("rstfill done", {31'b0, done}, 32'h0);
            rst = 1'b0; rd = 1'b0;
            @(negedge clk);
            init_mem();
            do_req(1'b1, 1'b0, 32'h6004, 32'h0, 1, ok, o_hit, o_dv, o_data,
                   o_lat, ev_seen, ev_addr, ev_line, ev_stable, fl_seen, fl_addr, fl_lat);
            chk("rstfill after_done", {31'b0, ok}, 32'h1);
            chk("rstfill after_miss", {31'b0, o_hit}, 32'h0);
            chk("rstfill after_data", o_data, 32'hDEAD_BEEF);
        end

        // Random traffic against the flat reference
        begin
            logic        w;
            logic [31:0] a, d;
`ifdef MEM_CACHE_STATS_EN
            logic [31:0] before;
            before = hit_count + miss_count;
`endif
            for (int i = 0; i < 1000; i++) begin
                w = 1'($urandom_range(0, 1));
                a = 32'($urandom_range(0, 16383)) << 2;
                d = $urandom;
                do_req(~w, w, a, d, int'($urandom_range(0, 3)), ok, o_hit, o_dv, o_data,
                       o_lat, ev_seen, ev_addr, ev_line, ev_stable, fl_seen, fl_addr, fl_lat);
                chk($sformatf("rnd%0d done", i), {31'b0, ok}, 32'h1);
                if (!w) chk($sformatf("rnd%0d data a=%h", i, a), o_data, ref_word(a));
            end
`ifdef MEM_CACHE_STATS_EN
            chk("stats total", hit_count + miss_count - before, 32'd1000);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
